// File: rtl/adbg_biu_burst_ctrl.sv
// Debug BIU burst initiator: splits one burst command into single strobe/ready transfers.
// Optional ADBG_BIU_BURST_STOP_ON_ERR_EN: end the burst after the first word that returns biu_err.
module adbg_biu_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  biu_clk,
  input  logic                  biu_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_size,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  biu_strb,
  output logic                  biu_rw,
  output logic [ADDR_WIDTH-1:0] biu_addr,
  output logic [DATA_WIDTH-1:0] biu_di,
  output logic [3:0]            biu_word_size,
  input  logic                  biu_rdy,
  input  logic [DATA_WIDTH-1:0] biu_do,
  input  logic                  biu_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RETURN = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]            state;
  logic                  we_q;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_word;
  logic                  stop_wait;
  logic                  stop_ret;

  function automatic logic [3:0] norm_size(input logic [3:0] s);
    case (s)
      4'd1, 4'd2: norm_size = s;
      default:    norm_size = 4'd4;
    endcase
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_FETCH);
  assign biu_strb  = (state == S_ISSUE);
  assign rd_valid  = (state == S_RETURN);
  assign done      = (state == S_DONE);

  assign next_addr = biu_addr + ADDR_WIDTH'(biu_word_size);
  assign last_word = (remaining == CNT_WIDTH'(1));

`ifdef ADBG_BIU_BURST_STOP_ON_ERR_EN
  logic stop_q;
  assign stop_wait = biu_err;
  assign stop_ret  = stop_q;

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst)                                stop_q <= 1'b0;
    else if (state == S_IDLE)                   stop_q <= 1'b0;
    else if (state == S_WAIT && biu_rdy)        stop_q <= biu_err;
  end
`else
  assign stop_wait = 1'b0;
  assign stop_ret  = 1'b0;
`endif

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      remaining     <= '0;
      biu_addr      <= '0;
      biu_di        <= '0;
      biu_rw        <= 1'b1;
      biu_word_size <= 4'd4;
      rd_data       <= '0;
      err           <= 1'b0;
      err_addr      <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          we_q          <= cmd_we;
          biu_rw        <= ~cmd_we;
          biu_addr      <= cmd_addr;
          biu_word_size <= norm_size(cmd_size);
          remaining     <= cmd_count;
          err           <= 1'b0;
          err_addr      <= '0;
          if (cmd_count == '0) state <= S_DONE;
          else                 state <= cmd_we ? S_FETCH : S_ISSUE;
        end
        S_FETCH: if (wr_valid) begin
          // BIU expects short write words in the upper byte lanes
          case (biu_word_size)
            4'd1:    biu_di <= {wr_data[7:0],  {(DATA_WIDTH-8){1'b0}}};
            4'd2:    biu_di <= {wr_data[15:0], {(DATA_WIDTH-16){1'b0}}};
            default: biu_di <= wr_data;
          endcase
          state <= S_ISSUE;
        end
        S_ISSUE: if (biu_rdy) state <= S_WAIT;
        S_WAIT: if (biu_rdy) begin
          if (biu_err && !err) begin
            err      <= 1'b1;
            err_addr <= biu_addr;
          end
          if (!we_q) begin
            case (biu_word_size)
              4'd1:    rd_data <= {{(DATA_WIDTH-8){1'b0}},  biu_do[7:0]};
              4'd2:    rd_data <= {{(DATA_WIDTH-16){1'b0}}, biu_do[15:0]};
              default: rd_data <= biu_do;
            endcase
            state <= S_RETURN;
          end else if (last_word || stop_wait) begin
            state <= S_DONE;
          end else begin
            remaining <= remaining - CNT_WIDTH'(1);
            biu_addr  <= next_addr;
            state     <= S_FETCH;
          end
        end
        S_RETURN: if (rd_ready) begin
          if (last_word || stop_ret) begin
            state <= S_DONE;
          end else begin
            remaining <= remaining - CNT_WIDTH'(1);
            biu_addr  <= next_addr;
            state     <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
